inst_fetcher: RTL

INST_FETCHER -- requirements
Module: inst_fetcher

---
 rtl/inst_fetcher_pkg.sv | 34 +++
 rtl/inst_fetcher_if.sv | 46 ++++
 rtl/inst_fetcher.sv | 138 +++++++++++++
 3 files changed

// File: rtl/inst_fetcher_pkg.sv
// Shared widths, FSM encodings and helpers for the byte-serial instruction fetcher.
// Pure constants/types: no latency, no flow control of its own.
// Imported by the fetch interface and the fetcher core.
package inst_fetcher_pkg;

  localparam int ADDR_W = 32;
  localparam int BYTE_W = 8;
  localparam int INST_W = 32;

  // issue_idx runs 0..4; 4 means all four bytes of the word have been requested
  localparam logic [2:0] ISSUE_DONE = 3'd4;
  // Byte lane whose arrival completes a little-endian word
  localparam logic [1:0] LAST_LANE  = 2'd3;
  // Sequential step between instruction words
  localparam logic [ADDR_W-1:0] INST_STRIDE = 32'd4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [INST_W-1:0] inst_t;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_e;

  // Replace one little-endian byte lane of a word
  function automatic inst_t lane_insert(inst_t word, logic [1:0] lane, byte_t b);
    inst_t res;
    res = word;
    res[BYTE_W*lane +: BYTE_W] = b;
    return res;
  endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Memory-side and decoder-side signals of the instruction fetcher.
// Wires only: timing is defined by the fetcher core.
// master = fetcher, slave = memory controller / branch unit / decoder.
interface inst_fetcher_if;
  import inst_fetcher_pkg::*;

  // Memory controller side
  logic  fetch_mem_rdy;
  byte_t mem_byte;
  addr_t fetch_req_addr;

  // Branch resolution side
  logic  jump_en;
  addr_t jump_pc;

  // Decoder side
  logic  dec_ready;
  logic  inst_valid;
  inst_t inst_out;
  addr_t inst_pc;

  modport master (
    input  fetch_mem_rdy,
    input  mem_byte,
    input  jump_en,
    input  jump_pc,
    input  dec_ready,
    output fetch_req_addr,
    output inst_valid,
    output inst_out,
    output inst_pc
  );

  modport slave (
    output fetch_mem_rdy,
    output mem_byte,
    output jump_en,
    output jump_pc,
    output dec_ready,
    input  fetch_req_addr,
    input  inst_valid,
    input  inst_out,
    input  inst_pc
  );

endinterface

// File: rtl/inst_fetcher.sv
// Byte-serial instruction fetcher: four RAM byte reads assembled little-endian into one word.
// Latency: 5 cycles from first byte issue to inst_valid, +1 per cycle fetch_mem_rdy is low.
// Backpressure: word held (no issue) until inst_valid & dec_ready; rdy_in low pauses everything.
module inst_fetcher
  import inst_fetcher_pkg::*;
(
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  inst_fetcher_if.master bus
);

  fetch_state_e state_q, state_d;
  addr_t        pc_q, pc_d;
  logic [2:0]   issue_idx_q, issue_idx_d;
  logic         pend_q, pend_d;
  logic [1:0]   pend_idx_q, pend_idx_d;
  inst_t        buf_q, buf_d;
  inst_t        inst_out_q, inst_out_d;
  addr_t        inst_pc_q, inst_pc_d;
  logic         inst_valid_q, inst_valid_d;

  logic         issue_ok;
  logic         handshake;
  inst_t        asm_word;

  // Request address is pc plus the byte offset being issued; wraps at 32 bits
  assign bus.fetch_req_addr = pc_q + {29'd0, issue_idx_q};
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst_out       = inst_out_q;
  assign bus.inst_pc        = inst_pc_q;

  // Only FETCH with bytes still outstanding may consume a memory slot
  assign issue_ok  = (state_q == ST_FETCH) && (issue_idx_q != ISSUE_DONE) && bus.fetch_mem_rdy;
  assign handshake = inst_valid_q && bus.dec_ready;

  // Buffer with the byte landing this cycle merged in, so the last byte reaches inst_out directly
  always_comb begin
    asm_word = buf_q;
    if (pend_q) begin
      asm_word = lane_insert(buf_q, pend_idx_q, bus.mem_byte);
    end
  end

  // Next-state logic: pause beats jump, jump beats issue/assembly/handshake
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    issue_idx_d  = issue_idx_q;
    pend_d       = pend_q;
    pend_idx_d   = pend_idx_q;
    buf_d        = buf_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;

    if (!rdy_in) begin
      // The in-flight byte is dropped, so rewind the issue pointer to re-request it
      if (pend_q) begin
        pend_d      = 1'b0;
        issue_idx_d = {1'b0, pend_idx_q};
      end
    end else if (bus.jump_en) begin
      // Clearing pend also discards whatever byte the memory returns next cycle
      pc_d         = bus.jump_pc;
      issue_idx_d  = 3'd0;
      pend_d       = 1'b0;
      inst_valid_d = 1'b0;
      state_d      = ST_FETCH;
    end else begin
      buf_d = asm_word;

      if (issue_ok) begin
        pend_d      = 1'b1;
        pend_idx_d  = issue_idx_q[1:0];
        issue_idx_d = issue_idx_q + 3'd1;
      end else begin
        pend_d      = 1'b0;
      end

      case (state_q)
        ST_FETCH: begin
          if (pend_q && (pend_idx_q == LAST_LANE)) begin
            inst_out_d   = asm_word;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            state_d      = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (handshake) begin
            pc_d         = pc_q + INST_STRIDE;
            issue_idx_d  = 3'd0;
            inst_valid_d = 1'b0;
            state_d      = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  // All fetcher state, with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= ST_FETCH;
      pc_q         <= '0;
      issue_idx_q  <= 3'd0;
      pend_q       <= 1'b0;
      pend_idx_q   <= 2'd0;
      buf_q        <= '0;
      inst_out_q   <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      issue_idx_q  <= issue_idx_d;
      pend_q       <= pend_d;
      pend_idx_q   <= pend_idx_d;
      buf_q        <= buf_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // Structural invariants of the issue pointer and the valid/state pairing
  a_issue_range: assert property (@(posedge clk_in) disable iff (!rst_in)
    issue_idx_q <= ISSUE_DONE);
  a_valid_hold: assert property (@(posedge clk_in) disable iff (!rst_in)
    inst_valid_q == (state_q == ST_HOLD));
  a_hold_no_pend: assert property (@(posedge clk_in) disable iff (!rst_in)
    (state_q == ST_HOLD) |-> !pend_q);

endmodule
